// File: rtl/uart_coord_tx_pkg.sv
// Shared definitions for the coordinate UART transmitter: FSM states, packet/frame
// sizes, default bit period and the packet byte mapping (used with UART_COORD_TX_CTS_EN builds too).
package uart_coord_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   localparam int PKT_BYTES            = 4;
   localparam int FRAME_BITS           = 10;
   localparam int DEFAULT_CLKS_PER_BIT = 868;

   // Byte order on the wire: x low, x high bits, y low, y high bits.
   function automatic logic [7:0] coord_byte(input logic [1:0] idx,
                                             input logic [9:0] x,
                                             input logic [9:0] y);
      logic [7:0] b;
      case (idx)
         2'd0:    b = x[7:0];
         2'd1:    b = {6'b0, x[9:8]};
         2'd2:    b = y[7:0];
         default: b = {6'b0, y[9:8]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// 8N1 byte serializer. Accepts a new byte while idle or in the final stop-bit
// cycle, so consecutive bytes run back to back with no idle gap.
module uart_tx_ctrl
   import uart_coord_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] byte_tx,
   input  logic       start_tx,
   output logic       uart_tx,
   output logic       done_tx,
   output logic       busy
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          bit_end;

   assign bit_end = (cnt == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_idx <= bit_idx_nx;
         shreg   <= shreg_nx;
      end
   end

   // Outputs decode the state directly so reset forces the idle line at once.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      uart_tx    = 1'b1;
      busy       = 1'b1;
      done_tx    = 1'b0;
      if (state != ST_IDLE) begin
         cnt_nx = bit_end ? '0 : cnt + 1'b1;
      end
      case (state)
         ST_IDLE: begin
            busy = 1'b0;
            if (start_tx) begin
               state_nx = ST_START;
               shreg_nx = byte_tx;
            end
         end
         ST_START: begin
            uart_tx = 1'b0;
            if (bit_end) begin
               state_nx   = ST_DATA;
               bit_idx_nx = '0;
            end
         end
         ST_DATA: begin
            uart_tx = shreg[0];
            if (bit_end) begin
               shreg_nx   = {1'b0, shreg[7:1]};
               bit_idx_nx = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_nx = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               busy     = 1'b0;
               done_tx  = 1'b1;
               state_nx = ST_IDLE;
               if (start_tx) begin
                  state_nx = ST_START;
                  shreg_nx = byte_tx;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_coord_tx.sv
// Sends one 4-byte X/Y coordinate packet over UART per accepted send.
// Define UART_COORD_TX_CTS_EN to hold each start bit until cts_n is low.
module uart_coord_tx
   import uart_coord_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       send,
   input  logic [9:0] x_coordinate,
   input  logic [9:0] y_coordinate,
   input  logic       cts_n,
   output logic       uart_tx,
   output logic       busy,
   output logic       done_tx
);

   logic       ctrl_start, ctrl_busy, ctrl_done;
   logic [7:0] ctrl_byte;
   logic       pkt_active, pend;
   logic [1:0] byte_idx, idx_nx;
   logic [9:0] x_q, y_q;
   logic       pkt_done, accept, want_next, req, cts_ok;

`ifdef UART_COORD_TX_CTS_EN
   assign cts_ok = !cts_n;
`else
   logic unused_cts;
   assign unused_cts = cts_n;
   assign cts_ok     = 1'b1;
`endif

   assign pkt_done  = pkt_active && ctrl_done && (byte_idx == 2'(PKT_BYTES - 1));
   assign busy      = pkt_active && !pkt_done;
   assign done_tx   = pkt_done;
   assign accept    = send && !busy;
   assign want_next = pkt_active && ctrl_done && !pkt_done;
   // pend remembers a byte that is due but held back by flow control.
   assign req        = accept || want_next || pend;
   assign ctrl_start = req && cts_ok && !ctrl_busy;
   assign idx_nx     = accept ? 2'd0 : (want_next ? byte_idx + 2'd1 : byte_idx);
   // The first byte comes straight from the inputs since the latch updates this cycle.
   assign ctrl_byte  = accept ? coord_byte(idx_nx, x_coordinate, y_coordinate)
                              : coord_byte(idx_nx, x_q, y_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pkt_active <= 1'b0;
         pend       <= 1'b0;
         byte_idx   <= '0;
         x_q        <= '0;
         y_q        <= '0;
      end else begin
         pend     <= req && !ctrl_start;
         byte_idx <= idx_nx;
         if (accept) begin
            x_q        <= x_coordinate;
            y_q        <= y_coordinate;
            pkt_active <= 1'b1;
         end else if (pkt_done) begin
            pkt_active <= 1'b0;
         end
      end
   end

   uart_tx_ctrl #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .byte_tx (ctrl_byte),
      .start_tx(ctrl_start),
      .uart_tx (uart_tx),
      .done_tx (ctrl_done),
      .busy    (ctrl_busy)
   );

endmodule
